// File: rtl/stage_writeback.sv
// stage_writeback: final pipeline stage, directly downstream of stage_execute.
//
// Execute results that write a real register (wb_en=1 and rd!=0) are buffered
// in a DEPTH-entry in-order retirement queue. The queue drains into the
// register-file write port. Every occupied entry is exposed on the wb_* bypass
// bus for stage_issue, with slot 0 always the youngest entry.
//
// Optional feature macro: STAGE_WRITEBACK_RETIRE_COUNTER_EN
//   defined   -> retire_count_o counts retired instructions (filtered pushes
//                plus rf write handshakes), wrapping mod 2^32
//   undefined -> retire_count_o is tied to 0
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   execute_result_i/rd_i    result and destination register from execute
//   execute_wb_en_i          instruction writes a register
//   execute_valid_i/ready_o  upstream valid/ready handshake
//   rf_addr_o/rf_data_o      register-file write index and data (queue head)
//   rf_valid_o/rf_ready_i    register-file write handshake
//   wb_addr_o/wb_data_o      bypass rd/data, slot i at [5i+4:5i]/[32i+31:32i]
//   wb_valid_o               slot i occupied
//   wb_ready_o               slot i is the youngest occupied entry for its rd
//   retire_count_o           retired instruction count (optional)

module stage_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           execute_result_i,
  input  logic [4:0]            execute_rd_i,
  input  logic                  execute_wb_en_i,
  input  logic                  execute_valid_i,
  output logic                  execute_ready_o,
  output logic [4:0]            rf_addr_o,
  output logic [31:0]           rf_data_o,
  output logic                  rf_valid_o,
  input  logic                  rf_ready_i,
  output logic [DEPTH*5-1:0]    wb_addr_o,
  output logic [DEPTH*32-1:0]   wb_data_o,
  output logic [DEPTH-1:0]      wb_valid_o,
  output logic [DEPTH-1:0]      wb_ready_o,
  output logic [31:0]           retire_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic transfer;
  logic push;
  logic filtered;
  logic pop;

  logic [4:0]    slot_rd    [DEPTH];
  logic [DEPTH-1:0] slot_valid;

  // Handshake decode. A full queue still accepts when the head retires in the
  // same cycle, since the freed entry is reused by the incoming push.
  assign pop             = rf_valid_o & rf_ready_i;
  assign execute_ready_o = (count < CW'(DEPTH)) | pop;
  assign transfer        = execute_valid_i & execute_ready_o;
  assign push            = transfer & execute_wb_en_i & (execute_rd_i != 5'd0);
  assign filtered        = transfer & ~(execute_wb_en_i & (execute_rd_i != 5'd0));

  // The rf port always presents the head; it is only ever registered state,
  // so it cannot change while a write is stalled.
  assign rf_valid_o = (count != '0);
  assign rf_addr_o  = mem_rd[head];
  assign rf_data_o  = mem_data[head];

  // Queue storage and pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_rd[tail]   <= execute_rd_i;
        mem_data[tail] <= execute_result_i;
        tail           <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Bypass bus: slot i maps to the i-th youngest entry (tail-1-i). Slots past
  // the occupancy are forced to zero so consumers never see stale data.
  always_comb begin
    wb_addr_o  = '0;
    wb_data_o  = '0;
    wb_valid_o = '0;
    slot_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx           = tail - PW'(i) - PW'(1);
      slot_valid[i] = (CW'(i) < count);
      slot_rd[i]    = slot_valid[i] ? mem_rd[idx] : 5'd0;
      wb_valid_o[i] = slot_valid[i];
      if (slot_valid[i]) begin
        wb_addr_o[5*i +: 5]   = mem_rd[idx];
        wb_data_o[32*i +: 32] = mem_data[idx];
      end
    end
  end

  // A slot is ready only if no younger slot targets the same register, so
  // issue picks up exactly the newest value for each rd.
  always_comb begin
    wb_ready_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic shadowed;
      shadowed = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j < i && slot_valid[j] && slot_rd[j] == slot_rd[i]) begin
          shadowed = 1'b1;
        end
      end
      wb_ready_o[i] = slot_valid[i] & ~shadowed;
    end
  end

`ifdef STAGE_WRITEBACK_RETIRE_COUNTER_EN
  logic [31:0] retire_count_q;

  // Filtered transfers retire immediately; queued ones retire on the rf write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_count_q <= '0;
    end else begin
      retire_count_q <= retire_count_q + 32'(filtered) + 32'(pop);
    end
  end

  assign retire_count_o = retire_count_q;
`else
  logic unused_filtered;
  assign unused_filtered = filtered;
  assign retire_count_o  = '0;
`endif

endmodule

// File: tb/tb_stage_writeback.sv
// Directed testbench for stage_writeback (DEPTH=4).
module tb_stage_writeback;

  localparam int DEPTH = 4;

  logic              clk_i;
  logic              rst_ni;
  logic [31:0]       execute_result_i;
  logic [4:0]        execute_rd_i;
  logic              execute_wb_en_i;
  logic              execute_valid_i;
  logic              execute_ready_o;
  logic [4:0]        rf_addr_o;
  logic [31:0]       rf_data_o;
  logic              rf_valid_o;
  logic              rf_ready_i;
  logic [DEPTH*5-1:0]  wb_addr_o;
  logic [DEPTH*32-1:0] wb_data_o;
  logic [DEPTH-1:0]  wb_valid_o;
  logic [DEPTH-1:0]  wb_ready_o;
  logic [31:0]       retire_count_o;

  int passed;
  int failed;
  int total;
  logic [31:0] exp_retire;

  stage_writeback #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .execute_result_i (execute_result_i),
    .execute_rd_i     (execute_rd_i),
    .execute_wb_en_i  (execute_wb_en_i),
    .execute_valid_i  (execute_valid_i),
    .execute_ready_o  (execute_ready_o),
    .rf_addr_o        (rf_addr_o),
    .rf_data_o        (rf_data_o),
    .rf_valid_o       (rf_valid_o),
    .rf_ready_i       (rf_ready_i),
    .wb_addr_o        (wb_addr_o),
    .wb_data_o        (wb_data_o),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_o       (wb_ready_o),
    .retire_count_o   (retire_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic wb_en,
                               input logic [4:0] rd, input logic [31:0] data);
    execute_valid_i  = valid;
    execute_wb_en_i  = wb_en;
    execute_rd_i     = rd;
    execute_result_i = data;
  endtask

  task automatic checkRetire(input string tag);
`ifdef STAGE_WRITEBACK_RETIRE_COUNTER_EN
    checkOutput(tag, 128'(retire_count_o), 128'(exp_retire));
`else
    checkOutput(tag, 128'(retire_count_o), 128'd0);
`endif
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    exp_retire = 0;
    rst_ni     = 1'b0;
    rf_ready_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);

    // Reset state
    #12;
    checkOutput("rst_rf_valid", 128'(rf_valid_o), 128'd0);
    checkOutput("rst_wb_valid", 128'(wb_valid_o), 128'd0);
    checkOutput("rst_wb_ready", 128'(wb_ready_o), 128'd0);
    checkOutput("rst_wb_addr",  128'(wb_addr_o),  128'd0);
    checkOutput("rst_exec_ready", 128'(execute_ready_o), 128'd1);
    checkRetire("rst_retire");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // Single push, drained immediately
    rf_ready_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    checkOutput("no_bypass_through", 128'(rf_valid_o), 128'd0);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("single_rf_valid", 128'(rf_valid_o), 128'd1);
    checkOutput("single_rf_addr",  128'(rf_addr_o), 128'd5);
    checkOutput("single_rf_data",  128'(rf_data_o), 128'hDEADBEEF);
    checkOutput("single_wb_valid", 128'(wb_valid_o), 128'b0001);
    checkOutput("single_wb_ready", 128'(wb_ready_o), 128'b0001);
    checkOutput("single_wb_addr0", 128'(wb_addr_o[4:0]), 128'd5);
    step();
    exp_retire = exp_retire + 1;
    checkOutput("single_empty", 128'(rf_valid_o), 128'd0);
    checkOutput("single_wb_empty", 128'(wb_valid_o), 128'd0);
    checkRetire("single_retire");

    // Fill to full with rf stalled
    rf_ready_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b1, 5'(k), 32'(k * 32'h11));
      step();
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("full_exec_ready", 128'(execute_ready_o), 128'd0);
    checkOutput("full_wb_addr", 128'(wb_addr_o), 128'({5'd1, 5'd2, 5'd3, 5'd4}));
    checkOutput("full_wb_data0", 128'(wb_data_o[31:0]), 128'h44);
    checkOutput("full_wb_valid", 128'(wb_valid_o), 128'hF);
    checkOutput("full_wb_ready", 128'(wb_ready_o), 128'hF);
    checkOutput("full_rf_addr", 128'(rf_addr_o), 128'd1);
    step();
    checkOutput("stall_rf_addr", 128'(rf_addr_o), 128'd1);
    checkOutput("stall_rf_data", 128'(rf_data_o), 128'h11);

    // Drain in order
    rf_ready_i = 1'b1;
    #1;
    checkOutput("full_pop_exec_ready", 128'(execute_ready_o), 128'd1);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("drain_rf_addr", 128'(rf_addr_o), 128'(k));
      checkOutput("drain_rf_data", 128'(rf_data_o), 128'(k * 32'h11));
      step();
      exp_retire = exp_retire + 1;
    end
    checkOutput("drain_empty", 128'(rf_valid_o), 128'd0);
    checkRetire("drain_retire");

    // Full queue with continuous push/pop across pointer wrap
    rf_ready_i = 1'b0;
    for (int k = 10; k <= 13; k++) begin
      applyStimulus(1'b1, 1'b1, 5'(k), 32'hC000_0000 | 32'(k));
      step();
    end
    rf_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b1, 5'(14 + k), 32'hC000_0000 | 32'(14 + k));
      #1;
      checkOutput("stream_exec_ready", 128'(execute_ready_o), 128'd1);
      checkOutput("stream_rf_addr", 128'(rf_addr_o), 128'(10 + k));
      checkOutput("stream_rf_data", 128'(rf_data_o), 128'(32'hC000_0000 | 32'(10 + k)));
      checkOutput("stream_wb_valid", 128'(wb_valid_o), 128'hF);
      step();
      exp_retire = exp_retire + 1;
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    for (int k = 20; k <= 23; k++) begin
      checkOutput("stream_tail_addr", 128'(rf_addr_o), 128'(k));
      step();
      exp_retire = exp_retire + 1;
    end
    checkOutput("stream_empty", 128'(rf_valid_o), 128'd0);
    checkRetire("stream_retire");

    // Same rd twice: only the youngest is ready
    rf_ready_i = 1'b0;
    applyStimulus(1'b1, 1'b1, 5'd7, 32'hA);
    step();
    applyStimulus(1'b1, 1'b1, 5'd7, 32'hB);
    step();
    applyStimulus(1'b1, 1'b1, 5'd3, 32'hC);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("dup_wb_valid", 128'(wb_valid_o), 128'b0111);
    checkOutput("dup_wb_ready", 128'(wb_ready_o), 128'b0011);
    checkOutput("dup_wb_data0", 128'(wb_data_o[31:0]), 128'hC);
    checkOutput("dup_wb_data1", 128'(wb_data_o[63:32]), 128'hB);
    checkOutput("dup_wb_data2", 128'(wb_data_o[95:64]), 128'hA);
    rf_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      exp_retire = exp_retire + 1;
    end
    checkOutput("dup_empty", 128'(rf_valid_o), 128'd0);

    // Filtered pushes: rd=0 and wb_en=0
    applyStimulus(1'b1, 1'b1, 5'd0, 32'h55);
    #1;
    checkOutput("filt_rd0_ready", 128'(execute_ready_o), 128'd1);
    step();
    exp_retire = exp_retire + 1;
    applyStimulus(1'b1, 1'b0, 5'd9, 32'h99);
    step();
    exp_retire = exp_retire + 1;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("filt_rf_valid", 128'(rf_valid_o), 128'd0);
    checkOutput("filt_wb_valid", 128'(wb_valid_o), 128'd0);
    checkRetire("filt_retire");

    // Reset mid-operation
    rf_ready_i = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b1, 5'(k), 32'(k));
      step();
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("pre_rst_wb_valid", 128'(wb_valid_o), 128'b0111);
    #2;
    rst_ni = 1'b0;
    #1;
    exp_retire = 0;
    checkOutput("mid_rst_rf_valid", 128'(rf_valid_o), 128'd0);
    checkOutput("mid_rst_wb_valid", 128'(wb_valid_o), 128'd0);
    checkOutput("mid_rst_exec_ready", 128'(execute_ready_o), 128'd1);
    checkRetire("mid_rst_retire");
    @(negedge clk_i);
    rst_ni = 1'b1;
    rf_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("post_rst_rf_valid", 128'(rf_valid_o), 128'd0);
    end
    checkOutput("post_rst_exec_ready", 128'(execute_ready_o), 128'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stage_writeback.md
Name: stage_writeback

Overview:
Final pipeline stage, directly downstream of stage_execute. Accepts execute results with their destination register, buffers them in a DEPTH-entry in-order retirement queue, and drains the queue into the register-file write port. Every occupied queue entry is exposed on the wb_* bypass bus consumed by stage_issue, with slot 0 always the youngest entry.

Parameters:
DEPTH, 4, retirement queue entries; bypass bus slots. Power of two, 2..8.

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_ni  in  1  asynchronous active-low reset
execute_result_i  in  32  ALU result from stage_execute
execute_rd_i  in  5  destination register index
execute_wb_en_i  in  1  instruction writes a register
execute_valid_i  in  1  upstream handshake valid
execute_ready_o  out  1  upstream handshake ready
rf_addr_o  out  5  register-file write index
rf_data_o  out  32  register-file write data
rf_valid_o  out  1  write request valid
rf_ready_i  in  1  register file accepts write
wb_addr_o  out  DEPTH*5  bypass rd per slot; slot i at [5i+4:5i]
wb_data_o  out  DEPTH*32  bypass data per slot; slot i at [32i+31:32i]
wb_valid_o  out  DEPTH  slot i occupied
wb_ready_o  out  DEPTH  slot i is the youngest occupied entry for its rd
retire_count_o  out  32  instructions retired (optional, see below)

Behaviour:
- Reset (rst_ni low, async): queue empty, head/tail/count = 0, rf_valid_o=0, wb_valid_o=0, wb_ready_o=0, wb_addr_o/wb_data_o=0, retire_count_o=0. execute_ready_o=1 once count=0 (comb).
- Upstream handshake: transfer when execute_valid_i & execute_ready_o at rising edge.
- execute_ready_o = (count < DEPTH) | (rf_valid_o & rf_ready_i). Combinational; simultaneous push and pop when full is allowed, count unchanged.
- Push filter: a transfer with execute_wb_en_i=0 or execute_rd_i=0 is accepted and counted as retired, but NOT enqueued.
- Enqueue: entry {rd, result} written at tail; tail = tail+1 mod DEPTH; count+1. Latency: enqueued data visible on wb_* and rf_* the cycle after the transfer.
- Drain: rf_valid_o = (count != 0); rf_addr_o/rf_data_o = head entry. On rf_valid_o & rf_ready_i: head = head+1 mod DEPTH, count-1. rf_* held stable while rf_valid_o & !rf_ready_i.
- Simultaneous push+pop: both pointers advance, count unchanged; empty queue with push+no pop -> count 1.
- No bypass-through of the in-flight execute transfer: empty queue -> rf_valid_o=0 that cycle.
- Bypass ordering: slot i = i-th youngest occupied entry (slot 0 = tail-1). Slots i >= count: wb_valid_o[i]=0, wb_ready_o[i]=0, addr/data=0.
- wb_ready_o[i] = wb_valid_o[i] & no younger occupied slot j<i has the same rd. At most one ready slot per rd.
- Pointer wrap: mod DEPTH, natural binary wrap; count is $clog2(DEPTH)+1 bits.
- Reset mid-operation: all queued entries discarded, no rf write issued after reset asserts.

Optional Feature:
STAGE_WRITEBACK_RETIRE_COUNTER_EN
- Defined: retire_count_o increments by 1 per upstream transfer that is filtered out, and by 1 per rf write handshake; both in one cycle -> +2. Wraps mod 2^32.
- Undefined: counter logic absent, retire_count_o tied to 0.

Test Plan:
- Reset, then push rd=5 data=0xDEADBEEF with rf_ready_i=1 -> next cycle rf_valid_o=1, rf_addr_o=5, rf_data_o=0xDEADBEEF, wb_valid_o=4'b0001, wb_ready_o=4'b0001; following cycle queue empty.
- rf_ready_i=0, push rd=1,2,3,4 (data 0x11..0x44) -> execute_ready_o=0 after fourth; wb_addr_o slot0..3 = 4,3,2,1; rf_addr_o=1; raise rf_ready_i -> drains 1,2,3,4 in order, one per cycle.
- Full queue, rf_ready_i=1, execute_valid_i=1 continuously -> execute_ready_o=1 every cycle, count stays 4, one push and one rf write per cycle across pointer wrap (>=10 transfers).
- rf_ready_i=0, push rd=7 data=0xA then rd=7 data=0xB -> wb_valid_o=4'b0011, wb_ready_o=4'b0001, slot0 data=0xB.
- Push rd=0 data=0x55 and wb_en=0 rd=9 -> both accepted, rf_valid_o stays 0, retire_count_o=2 (macro defined) / 0 (undefined).
- Three entries queued, rf_ready_i=0, assert rst_ni low mid-cycle -> rf_valid_o, wb_valid_o drop to 0 immediately; after release execute_ready_o=1, no stale rf writes.
